// File: rtl/input_debouncer.sv
// Purpose: synchronise a raw bouncy 1-bit input and release level changes only after they hold steady.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from input sample to out; no backpressure (free-running filter).
// bounce pulses for one cycle whenever a pending transition is abandoned because the level reverted.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic bounce
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // out is decoded from the next state so it stays a flop with no path from in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            out    <= 1'b0;
            bounce <= 1'b0;
        end else begin
            bounce <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state  <= IDLE_LOW;
                        bounce <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        out   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state  <= IDLE_HIGH;
                        bounce <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        out   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench: stimulus pushes expected output events (out edges, bounce pulses) with their cycle;
// a negedge monitor pops and compares every event either DUT presents.
module tb_input_debouncer;

    localparam int LAT0 = 6;
    localparam int LAT1 = 3;
    localparam int EV_OUT    = 0;
    localparam int EV_BOUNCE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, in0, out0, bounce0;
    logic rst1, in1, out1, bounce1;

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst0), .in(in0), .out(out0), .bounce(bounce0)
    );

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in(in1), .out(out1), .bounce(bounce1)
    );

    typedef struct {
        int cyc;
        int dut;
        int kind;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    bit   mon_en     = 1'b0;
    logic prev0      = 1'b0;
    logic prev1      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int at, input int dut, input int kind, input int val);
        exp_t e;
        e.cyc  = at;
        e.dut  = dut;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic observe(input int dut, input int kind, input int val);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: dut%0d kind=%0d val=%0d at cycle %0d, required no event",
                     dut, kind, val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.dut != dut || e.kind != kind || e.val != val) begin
                mismatched++;
                $display("FAIL event_match: got dut%0d kind=%0d val=%0d cycle=%0d, required dut%0d kind=%0d val=%0d cycle=%0d",
                         dut, kind, val, cyc, e.dut, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL missed_event: dut%0d kind=%0d val=%0d due cycle %0d, still outstanding at cycle %0d",
                         sb[0].dut, sb[0].kind, sb[0].val, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (out0 !== prev0) observe(0, EV_OUT, int'(out0));
            if (bounce0 !== 1'b0) observe(0, EV_BOUNCE, 1);
            if (out1 !== prev1) observe(1, EV_OUT, int'(out1));
            if (bounce1 !== 1'b0) observe(1, EV_BOUNCE, 1);
            prev0 = out0;
            prev1 = out1;
        end
    end

    initial begin
        // 1: reset with in held high, then full latency after release
        rst0 = 1'b1;
        rst1 = 1'b1;
        in0  = 1'b1;
        in1  = 1'b0;
        tick();
        check("rst_out_c1", out0, 0);
        check("rst_bounce_c1", bounce0, 0);
        tick();
        check("rst_out_c2", out0, 0);
        check("rst_bounce_c2", bounce0, 0);
        check("rst_out_dut1", out1, 0);
        rst0   = 1'b0;
        rst1   = 1'b0;
        mon_en = 1'b1;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 1);
        repeat (12) tick();

        // 2: clean steps fall, rise, fall
        in0 = 1'b0;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 0);
        repeat (12) tick();
        in0 = 1'b1;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 1);
        repeat (12) tick();
        in0 = 1'b0;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 0);
        repeat (12) tick();

        // 3: three-cycle glitch aborts in WAIT_HIGH
        in0 = 1'b1;
        expect_ev(cyc + 6, 0, EV_BOUNCE, 1);
        repeat (3) tick();
        in0 = 1'b0;
        repeat (10) tick();
        check("glitch_state", 32'(u_dut0.state), 0);
        check("glitch_out", out0, 0);

        // 4: bounce train 1,0,1,0,1 then held high
        in0 = 1'b1;
        expect_ev(cyc + 4, 0, EV_BOUNCE, 1);
        expect_ev(cyc + 6, 0, EV_BOUNCE, 1);
        expect_ev(cyc + 5 + LAT0, 0, EV_OUT, 1);
        tick(); in0 = 1'b0;
        tick(); in0 = 1'b1;
        tick(); in0 = 1'b0;
        tick(); in0 = 1'b1;
        repeat (14) tick();
        in0 = 1'b0;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 0);
        repeat (12) tick();

        // 5: reset while in WAIT_HIGH with cnt=2
        in0 = 1'b1;
        repeat (5) tick();
        check("pre_rst_state", 32'(u_dut0.state), 1);
        check("pre_rst_cnt", 32'(u_dut0.cnt), 2);
        rst0 = 1'b1;
        tick();
        check("mid_rst_out", out0, 0);
        check("mid_rst_cnt", 32'(u_dut0.cnt), 0);
        check("mid_rst_state", 32'(u_dut0.state), 0);
        rst0 = 1'b0;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 1);
        repeat (12) tick();
        in0 = 1'b0;
        expect_ev(cyc + 1 + LAT0, 0, EV_OUT, 0);
        repeat (12) tick();

        // 6: single-cycle debounce instance
        in1 = 1'b1;
        expect_ev(cyc + 1 + LAT1, 1, EV_OUT, 1);
        repeat (8) tick();
        in1 = 1'b0;
        expect_ev(cyc + 1 + LAT1, 1, EV_OUT, 0);
        repeat (8) tick();
        in1 = 1'b1;
        expect_ev(cyc + 4, 1, EV_BOUNCE, 1);
        tick();
        in1 = 1'b0;
        repeat (8) tick();
        check("pulse_out_dut1", out1, 0);

        repeat (5) tick();
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
